// File: rtl/waveform_packetizer_pkg.sv
// Shared constants and FSM encoding for the waveform packet framer.
package waveform_packetizer_pkg;

    localparam logic [31:0] DEF_CMD_WORD    = 32'h5757_4441;
    localparam int unsigned DEF_MAX_PAYLOAD = 251;
    localparam int unsigned HDR_WORDS       = 5;

    typedef logic [$clog2(HDR_WORDS)-1:0] hdr_idx_t;

    localparam hdr_idx_t HDR_CMD  = 3'd0;
    localparam hdr_idx_t HDR_ID   = 3'd1;
    localparam hdr_idx_t HDR_IND  = 3'd2;
    localparam hdr_idx_t HDR_LEN  = 3'd3;
    localparam hdr_idx_t HDR_RSVD = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_FIN
    } state_t;

endpackage

// File: rtl/waveform_packetizer.sv
// Frames a raw I/Q sample stream into AXI-Stream packets: 5-word header then
// up to MAX_PAYLOAD samples passed straight through from the source.
module waveform_packetizer
    import waveform_packetizer_pkg::*;
#(
    parameter logic [31:0] CMD_WORD    = DEF_CMD_WORD,
    parameter int unsigned MAX_PAYLOAD = DEF_MAX_PAYLOAD,
    parameter int unsigned LEN_W       = 32
) (
    input  logic             axi_tclk,
    input  logic             axi_tresetn,
    input  logic             start,
    input  logic [LEN_W-1:0] wfrm_id,
    input  logic [LEN_W-1:0] wfrm_len,
    output logic             busy,
    output logic             done,
    output logic             err_short,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    output logic [3:0]       m_axis_tkeep,
    input  logic             m_axis_tready
);

    state_t           r_state;
    state_t           w_state_nx;
    hdr_idx_t         r_hdr_cnt;
    logic [15:0]      r_pay_cnt;
    logic [LEN_W-1:0] r_id;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] r_ind;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_accept;
    logic             w_hdr_beat;
    logic             w_pay_beat;
    logic             w_rem_last;
    logic             w_pkt_last;
    logic             w_short;
    logic [15:0]      w_chunk;
    logic [31:0]      w_hdr_word;

    assign w_accept   = (r_state == ST_IDLE) & start;
    assign w_hdr_beat = (r_state == ST_HDR) & m_axis_tready;
    assign w_pay_beat = (r_state == ST_PAY) & s_axis_tvalid & m_axis_tready;
    assign w_rem_last = (r_rem == LEN_W'(1));
    assign w_pkt_last = (r_pay_cnt == 16'd1);
    // Source tlast anywhere but the final waveform word truncates the waveform.
    assign w_short    = w_pay_beat & s_axis_tlast & ~w_rem_last;
    assign w_chunk    = (r_rem > LEN_W'(MAX_PAYLOAD)) ? 16'(MAX_PAYLOAD) : r_rem[15:0];

    assign busy      = r_busy;
    assign done      = r_done;
    assign err_short = r_err;
    assign m_axis_tkeep = m_axis_tvalid ? 4'hf : 4'h0;

    always_comb begin
        w_hdr_word = '0;
        case (r_hdr_cnt)
            HDR_CMD:  w_hdr_word = CMD_WORD;
            HDR_ID:   w_hdr_word = 32'(r_id);
            HDR_IND:  w_hdr_word = 32'(r_ind);
            HDR_LEN:  w_hdr_word = 32'(r_len);
            default:  w_hdr_word = '0;
        endcase
    end

    always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
        if (!axi_tresetn) r_state <= ST_IDLE;
        else              r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx    = r_state;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start && (wfrm_len != '0)) w_state_nx = ST_HDR;
            end
            ST_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = w_hdr_word;
                if (w_hdr_beat && (r_hdr_cnt == HDR_RSVD)) w_state_nx = ST_PAY;
            end
            ST_PAY: begin
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tlast  = w_pkt_last | s_axis_tlast;
                s_axis_tready = m_axis_tready;
                if (w_pay_beat) begin
                    if (w_short || (w_pkt_last && w_rem_last)) w_state_nx = ST_FIN;
                    else if (w_pkt_last)                       w_state_nx = ST_HDR;
                end
            end
            ST_FIN:  w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
        if (!axi_tresetn) begin
            r_hdr_cnt <= '0;
            r_pay_cnt <= '0;
            r_id      <= '0;
            r_len     <= '0;
            r_rem     <= '0;
            r_ind     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (w_state_nx == ST_HDR) || (w_state_nx == ST_PAY);
            if (w_accept) begin
                r_err <= 1'b0;
                if (wfrm_len == '0) begin
                    r_done <= 1'b1;
                end else begin
                    r_id      <= wfrm_id;
                    r_len     <= wfrm_len;
                    r_rem     <= wfrm_len;
                    r_ind     <= '0;
                    r_hdr_cnt <= '0;
                end
            end
            if (w_hdr_beat) begin
                if (r_hdr_cnt == HDR_RSVD) r_pay_cnt <= w_chunk;
                else                       r_hdr_cnt <= r_hdr_cnt + 3'd1;
            end
            if (w_pay_beat) begin
                r_rem     <= r_rem - LEN_W'(1);
                r_pay_cnt <= r_pay_cnt - 16'd1;
                if (w_short) begin
                    r_err  <= 1'b1;
                    r_done <= 1'b1;
                end else if (w_pkt_last) begin
                    if (w_rem_last) begin
                        r_done <= 1'b1;
                    end else begin
                        r_ind     <= r_ind + LEN_W'(1);
                        r_hdr_cnt <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_waveform_packetizer.sv
// Directed bench for waveform_packetizer: framing, backpressure, zero length,
// ignored restart, short source and mid-packet reset.
`timescale 1ns/1ps
module tb_waveform_packetizer;

    localparam logic [31:0] CMD  = 32'h5757_4441;
    localparam int          MAXP = 251;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [31:0] wfrm_id  = '0;
    logic [31:0] wfrm_len = '0;
    logic        busy;
    logic        done;
    logic        err_short;
    logic [31:0] s_tdata  = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast  = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [3:0]  m_tkeep;
    logic        m_tready = 1'b0;

    always #5 clk = ~clk;

    waveform_packetizer #(
        .CMD_WORD    (CMD),
        .MAX_PAYLOAD (MAXP),
        .LEN_W       (32)
    ) dut (
        .axi_tclk      (clk),
        .axi_tresetn   (rst_n),
        .start         (start),
        .wfrm_id       (wfrm_id),
        .wfrm_len      (wfrm_len),
        .busy          (busy),
        .done          (done),
        .err_short     (err_short),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tready (m_tready)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_data[$];
    logic        exp_last[$];
    logic        exp_hdr[$];
    logic [31:0] got_data[$];
    logic        got_last[$];

    int          done_cnt, done_cyc, last_beat_cyc, stall_checks, stall_viol, keep_viol;
    logic        timed_out, busy_c1, err_c1, busy_after, done_after, err_after;
    logic        pre_rst_valid;
    logic [31:0] pre_rst_data;
    logic [41:0] rst_obs;

    function automatic logic [31:0] sample(input int k);
        return 32'hC000_0000 | 32'(k);
    endfunction

    // Reference framing: header {CMD,id,ind,len,0} then up to MAXP samples per packet.
    task automatic build_expected(input logic [31:0] id, input int len, input int short_at);
        int rem = len;
        int ind = 0;
        int k   = 0;
        bit stop = 0;
        exp_data.delete(); exp_last.delete(); exp_hdr.delete();
        while (rem > 0 && !stop) begin
            int chunk = (rem > MAXP) ? MAXP : rem;
            exp_data.push_back(CMD);        exp_last.push_back(1'b0); exp_hdr.push_back(1'b1);
            exp_data.push_back(id);         exp_last.push_back(1'b0); exp_hdr.push_back(1'b1);
            exp_data.push_back(32'(ind));   exp_last.push_back(1'b0); exp_hdr.push_back(1'b1);
            exp_data.push_back(32'(len));   exp_last.push_back(1'b0); exp_hdr.push_back(1'b1);
            exp_data.push_back(32'h0);      exp_last.push_back(1'b0); exp_hdr.push_back(1'b1);
            for (int j = 0; j < chunk; j++) begin
                bit sl = (k == short_at);
                exp_data.push_back(sample(k));
                exp_last.push_back((j == chunk - 1) || sl);
                exp_hdr.push_back(1'b0);
                k++;
                rem--;
                if (sl) begin
                    stop = 1;
                    break;
                end
            end
            ind++;
        end
    endtask

    task automatic run_stream(input logic [31:0] id, input logic [31:0] len, input int n_src,
                              input int tlast_at, input bit gaps, input int restart_at,
                              input int rst_at_beat, input int max_cyc);
        int          src = 0;
        bit          prev_stall = 0;
        logic [31:0] prev_data = '0;
        bit          seen_done = 0;
        got_data.delete(); got_last.delete();
        done_cnt = 0; done_cyc = -1; last_beat_cyc = -1;
        stall_checks = 0; stall_viol = 0; keep_viol = 0;
        timed_out = 1'b1; busy_c1 = 1'b0; err_c1 = 1'b1;
        busy_after = 1'b1; done_after = 1'b1; err_after = 1'b0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == 0) || (cyc == restart_at);
            if (cyc == restart_at) begin
                wfrm_id  = id ^ 32'hFF;
                wfrm_len = len + 32'd50;
            end else begin
                wfrm_id  = id;
                wfrm_len = len;
            end
            s_tvalid = (src < n_src) && (!gaps || $urandom_range(0, 3) != 0);
            s_tdata  = sample(src);
            s_tlast  = (src == tlast_at);
            m_tready = !gaps || ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (cyc == 1) begin
                busy_c1 = busy;
                err_c1  = err_short;
            end
            if (rst_at_beat >= 0 && got_data.size() == rst_at_beat) begin
                pre_rst_valid = m_tvalid;
                pre_rst_data  = m_tdata;
                rst_n = 1'b0;
                #1;
                rst_obs = {busy, done, err_short, s_tready, m_tvalid, m_tlast, m_tkeep, m_tdata};
                timed_out = 1'b0;
                start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
                return;
            end
            if (prev_stall) begin
                stall_checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== prev_data) stall_viol++;
            end
            prev_stall = m_tvalid && !m_tready && (got_data.size() < exp_hdr.size())
                         && exp_hdr[got_data.size()];
            prev_data  = m_tdata;
            if (m_tkeep !== (m_tvalid ? 4'hf : 4'h0)) keep_viol++;
            if (m_tvalid && m_tready) begin
                got_data.push_back(m_tdata);
                got_last.push_back(m_tlast);
                last_beat_cyc = cyc;
            end
            if (s_tvalid && s_tready) src++;
            if (done === 1'b1) begin
                done_cnt++;
                if (!seen_done) done_cyc = cyc;
                seen_done = 1;
            end
            if (seen_done && cyc == done_cyc + 1) begin
                busy_after = busy;
                done_after = done;
                err_after  = err_short;
                timed_out  = 1'b0;
                break;
            end
        end
        start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, err_short, s_tready, m_tvalid, m_tlast, m_tkeep, m_tdata} !== 42'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b srdy=%b mvld=%b mlast=%b keep=%h data=%h, expected all 0",
                     busy, done, err_short, s_tready, m_tvalid, m_tlast, m_tkeep, m_tdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_len1004();
        build_expected(32'd7, 1004, -1);
        run_stream(32'd7, 32'd1004, 1004, -1, 1'b0, -1, -1, 3000);
        n_cmp++;
        if (timed_out !== 1'b0) begin n_err++; $display("FAIL len1004_timeout: done not seen, expected within 3000 cycles"); end
        n_cmp++;
        if (got_data.size() != 1024) begin n_err++; $display("FAIL len1004_beats: got %0d, expected 1024", got_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL len1004_beat[%0d]: got data=%h last=%b, expected data=%h last=%b",
                         i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        n_cmp++;
        if (done_cnt != 1) begin n_err++; $display("FAIL len1004_done_count: got %0d, expected 1", done_cnt); end
        n_cmp++;
        if (done_cyc - last_beat_cyc != 1) begin n_err++; $display("FAIL len1004_done_latency: got %0d, expected 1", done_cyc - last_beat_cyc); end
        n_cmp++;
        if (busy_c1 !== 1'b1 || busy_after !== 1'b0) begin
            n_err++; $display("FAIL len1004_busy: got start=%b end=%b, expected 1 and 0", busy_c1, busy_after);
        end
        n_cmp++;
        if (err_after !== 1'b0 || done_after !== 1'b0) begin
            n_err++; $display("FAIL len1004_flags: got err=%b done_after=%b, expected 0 0", err_after, done_after);
        end
        n_cmp++;
        if (keep_viol != 0) begin n_err++; $display("FAIL len1004_tkeep: got %0d bad cycles, expected 0", keep_viol); end
    endtask

    task automatic test_len600();
        build_expected(32'h0000_0A5A, 600, -1);
        run_stream(32'h0000_0A5A, 32'd600, 600, -1, 1'b0, -1, -1, 2000);
        n_cmp++;
        if (timed_out !== 1'b0) begin n_err++; $display("FAIL len600_timeout: done not seen, expected within 2000 cycles"); end
        n_cmp++;
        if (got_data.size() != 615) begin n_err++; $display("FAIL len600_beats: got %0d, expected 615", got_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL len600_beat[%0d]: got data=%h last=%b, expected data=%h last=%b",
                         i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        n_cmp++;
        if (done_cnt != 1) begin n_err++; $display("FAIL len600_done_count: got %0d, expected 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        build_expected(32'd7, 1004, -1);
        run_stream(32'd7, 32'd1004, 1004, -1, 1'b1, -1, -1, 8000);
        n_cmp++;
        if (timed_out !== 1'b0) begin n_err++; $display("FAIL bp_timeout: done not seen, expected within 8000 cycles"); end
        n_cmp++;
        if (got_data.size() != 1024) begin n_err++; $display("FAIL bp_beats: got %0d, expected 1024", got_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL bp_beat[%0d]: got data=%h last=%b, expected data=%h last=%b",
                         i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        n_cmp++;
        if (stall_checks == 0 || stall_viol != 0) begin
            n_err++; $display("FAIL bp_hdr_stable: got %0d violations in %0d stalls, expected 0 in >0", stall_viol, stall_checks);
        end
        n_cmp++;
        if (done_cnt != 1) begin n_err++; $display("FAIL bp_done_count: got %0d, expected 1", done_cnt); end
        n_cmp++;
        if (keep_viol != 0) begin n_err++; $display("FAIL bp_tkeep: got %0d bad cycles, expected 0", keep_viol); end
    endtask

    task automatic test_len0_and_ignore();
        logic any_valid;
        logic d1, d2, b1;
        @(posedge clk); #1;
        start = 1'b1; wfrm_id = 32'd1; wfrm_len = 32'd0;
        @(negedge clk);
        any_valid = m_tvalid;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        any_valid = any_valid | m_tvalid;
        d1 = done;
        b1 = busy;
        @(negedge clk);
        any_valid = any_valid | m_tvalid;
        d2 = done;
        n_cmp++;
        if (d1 !== 1'b1 || d2 !== 1'b0) begin n_err++; $display("FAIL len0_done: got %b%b, expected 10", d1, d2); end
        n_cmp++;
        if (any_valid !== 1'b0 || b1 !== 1'b0) begin
            n_err++; $display("FAIL len0_quiet: got tvalid=%b busy=%b, expected 0 0", any_valid, b1);
        end

        build_expected(32'd3, 20, -1);
        run_stream(32'd3, 32'd20, 20, -1, 1'b0, 3, -1, 500);
        n_cmp++;
        if (timed_out !== 1'b0) begin n_err++; $display("FAIL ignore_timeout: done not seen, expected within 500 cycles"); end
        n_cmp++;
        if (got_data.size() != 25) begin n_err++; $display("FAIL ignore_beats: got %0d, expected 25", got_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL ignore_beat[%0d]: got data=%h last=%b, expected data=%h last=%b",
                         i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
            n_err++; $display("FAIL ignore_no_second: got busy=%b tvalid=%b, expected 0 0", busy, m_tvalid);
        end
    endtask

    task automatic test_short();
        build_expected(32'h33, 300, 99);
        run_stream(32'h33, 32'd300, 300, 99, 1'b0, -1, -1, 1000);
        n_cmp++;
        if (timed_out !== 1'b0) begin n_err++; $display("FAIL short_timeout: done not seen, expected within 1000 cycles"); end
        n_cmp++;
        if (got_data.size() != 105) begin n_err++; $display("FAIL short_beats: got %0d, expected 105", got_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL short_beat[%0d]: got data=%h last=%b, expected data=%h last=%b",
                         i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        n_cmp++;
        if (err_after !== 1'b1 || done_cnt != 1) begin
            n_err++; $display("FAIL short_err: got err=%b done_cnt=%0d, expected 1 1", err_after, done_cnt);
        end

        build_expected(32'h44, 3, -1);
        run_stream(32'h44, 32'd3, 3, -1, 1'b0, -1, -1, 200);
        n_cmp++;
        if (err_c1 !== 1'b0 || err_after !== 1'b0) begin
            n_err++; $display("FAIL short_clear: got err start=%b end=%b, expected 0 0", err_c1, err_after);
        end
        n_cmp++;
        if (got_data.size() != 8) begin n_err++; $display("FAIL clear_beats: got %0d, expected 8", got_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL clear_beat[%0d]: got data=%h last=%b, expected data=%h last=%b",
                         i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        build_expected(32'd5, 10, -1);
        run_stream(32'd5, 32'd10, 10, -1, 1'b0, -1, 2, 100);
        n_cmp++;
        if (pre_rst_valid !== 1'b1 || pre_rst_data !== 32'h0) begin
            n_err++; $display("FAIL rstmid_pre: got tvalid=%b data=%h, expected 1 00000000", pre_rst_valid, pre_rst_data);
        end
        n_cmp++;
        if (rst_obs !== 42'h0) begin n_err++; $display("FAIL rstmid_outputs: got %h, expected 0", rst_obs); end
        @(negedge clk);
        rst_n = 1'b1;
        build_expected(32'd6, 4, -1);
        run_stream(32'd6, 32'd4, 4, -1, 1'b0, -1, -1, 200);
        n_cmp++;
        if (got_data.size() != 9) begin n_err++; $display("FAIL rstmid_beats: got %0d, expected 9", got_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_cmp++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                n_err++;
                $display("FAIL rstmid_beat[%0d]: got data=%h last=%b, expected data=%h last=%b",
                         i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_len1004();
        test_len600();
        test_backpressure();
        test_len0_and_ignore();
        test_short();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
